// File: rtl/ifetch_seq_pkg.sv
// ifetch_seq_pkg: shared processor constants and fetch FSM state encoding
package ifetch_seq_pkg;
  localparam int WORD_W_DEF = 16;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD, S_HOLD} state_t;
endpackage

// File: rtl/ifetch_seq_pc_cnt.sv
// pc_cnt: program counter with load (priority) and wrapping increment
module pc_cnt #(
  parameter int WORD_W = 16,
  parameter logic [WORD_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              ld,
  input  logic [WORD_W-1:0] ld_val,
  output logic [WORD_W-1:0] pc
);
  // load beats increment; increment wraps at 2^WORD_W
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_VEC;
    else if (ld) pc <= ld_val;
    else if (inc) pc <= pc + WORD_W'(1);
endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: instruction fetch sequencer with redirect handling
module ifetch_seq
  import ifetch_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter logic [WORD_W-1:0] RESET_VEC = WORD_W'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir_d,
  output logic              en_ir,
  output logic              fetch_valid,
  input  logic              dec_ready,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  output logic [WORD_W-1:0] pc
);
  state_t r_state, w_nxt;
  logic r_pend, r_req, r_en, r_fv;
  logic [WORD_W-1:0] r_raddr, r_ir, w_ldv;
  logic w_ld, w_inc, w_cap, w_disc;

  pc_cnt #(.WORD_W(WORD_W), .RESET_VEC(RESET_VEC)) u_pc (
    .clk(clk), .rst(rst), .inc(w_inc), .ld(w_ld), .ld_val(w_ldv), .pc(pc)
  );

  // next state and pc control; an ack with any redirect outstanding is discarded
  always_comb begin
    w_nxt = r_state;
    w_ld = 1'b0;
    w_ldv = redirect_addr;
    w_inc = 1'b0;
    w_cap = 1'b0;
    w_disc = redirect | r_pend;
    case (r_state)
      S_IDLE: begin
        w_ld = redirect;
        w_nxt = start ? S_REQ : S_IDLE;
      end
      S_REQ: if (mem_ack) begin
        w_ld = w_disc;
        w_ldv = redirect ? redirect_addr : r_raddr;
        w_inc = !w_disc;
        w_cap = !w_disc;
        w_nxt = w_disc ? S_REQ : S_LOAD;
      end
      S_LOAD: begin
        w_ld = redirect;
        w_nxt = redirect ? S_REQ : S_HOLD;
      end
      default: begin
        w_ld = redirect;
        w_nxt = (redirect | dec_ready) ? S_REQ : S_HOLD;
      end
    endcase
  end

  // state, registered outputs decoded from next state, and pending redirect
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_req <= 1'b0;
      r_en <= 1'b0;
      r_fv <= 1'b0;
      r_ir <= '0;
      r_pend <= 1'b0;
      r_raddr <= '0;
    end else begin
      r_state <= w_nxt;
      r_req <= w_nxt == S_REQ;
      r_en <= w_nxt == S_LOAD;
      r_fv <= w_nxt == S_HOLD;
      if (w_cap) r_ir <= mem_rdata;
      if (r_state == S_REQ) begin
        r_pend <= !mem_ack & w_disc;
        if (redirect) r_raddr <= redirect_addr;
      end
    end

  assign mem_req = r_req;
  assign mem_addr = pc;
  assign ir_d = r_ir;
  assign en_ir = r_en;
  assign fetch_valid = r_fv;
endmodule

// File: doc/ifetch_seq.md
IFETCH_SEQ -- requirements
Module: ifetch_seq

Interface
REQ-001 The module SHALL have parameter WORD_W, default 16, giving the instruction and address width.
REQ-002 The module SHALL have parameter RESET_VEC, default 16'h0000, giving the PC value after reset.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port start  input  1  begins fetching from IDLE.
REQ-006 Port mem_req  output  1  is the memory read request.
REQ-007 Port mem_addr  output  WORD_W  is the read address.
REQ-008 Port mem_ack  input  1  indicates mem_rdata is valid this cycle.
REQ-009 Port mem_rdata  input  WORD_W  is the instruction word from memory.
REQ-010 Port ir_d  output  WORD_W  is the instruction word driven to the instruction register d_in.
REQ-011 Port en_ir  output  1  is the instruction-register load enable.
REQ-012 Port fetch_valid  output  1  indicates the instruction in the IR awaits decode.
REQ-013 Port dec_ready  input  1  indicates the decoder consumes the held instruction.
REQ-014 Port redirect  input  1  requests a PC change, for example a branch.
REQ-015 Port redirect_addr  input  WORD_W  is the new PC value.
REQ-016 Port pc  output  WORD_W  is the current program counter.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, LOAD and HOLD; all outputs SHALL be registered.
REQ-018 In IDLE, mem_req, en_ir and fetch_valid SHALL be 0; start=1 SHALL move the FSM to REQ on the next edge.
REQ-019 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal pc, held stable until mem_ack.
REQ-020 On REQ with mem_ack=1 and no pending redirect, the block SHALL capture mem_rdata into ir_d, set pc to pc+1 (modulo 2^WORD_W, so 16'hFFFF wraps to 0), and move to LOAD.
REQ-021 In LOAD, en_ir SHALL be 1 for exactly one cycle and ir_d SHALL be stable; the FSM SHALL then move to HOLD.
REQ-022 In HOLD, fetch_valid SHALL be 1; dec_ready=1 SHALL move the FSM to REQ on the next edge, so the request-to-request minimum is 3 cycles plus memory latency.
REQ-023 redirect=1 in LOAD or HOLD SHALL set pc to redirect_addr, clear fetch_valid and move to REQ; it SHALL take priority over dec_ready.
REQ-024 redirect=1 in REQ SHALL NOT change mem_addr; it SHALL set a pending flag and store redirect_addr.
REQ-025 When the acknowledging mem_ack arrives with the pending flag set, the data SHALL be discarded, no en_ir SHALL be issued, pc SHALL be set to the stored address, the flag SHALL be cleared, and the FSM SHALL re-enter REQ.
REQ-026 redirect and mem_ack in the same REQ cycle SHALL be treated as a pending redirect, with the data discarded.
REQ-027 A later redirect while one is already pending SHALL overwrite the stored address.
REQ-028 redirect in IDLE SHALL load pc without leaving IDLE.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 mem_ack outside REQ SHALL be ignored.

Reset
REQ-031 While rst=1, the following SHALL hold: state=IDLE, pc=RESET_VEC, ir_d=0, mem_req=0, mem_addr=RESET_VEC, en_ir=0, fetch_valid=0, pending flag=0.
REQ-032 Reset asserted mid-transaction SHALL drop mem_req immediately, with no en_ir pulse after release.
REQ-033 After release, the block SHALL wait for start.

Structure
REQ-034 The state encodings, WORD_W and RESET_VEC defaults SHALL live in a shared processor constants package/include, reused by the instruction register and decoder.
REQ-035 The PC register with its increment and load logic SHALL be a sub-module named pc_cnt (inputs inc, ld and ld_val; output pc).

Verification
REQ-036 Scenario: reset, start=1, mem_ack one cycle after mem_req with rdata=16'h00B1 -> mem_addr=0, then ir_d=16'h00B1 with a single en_ir pulse, pc=1, fetch_valid=1.
REQ-037 Scenario: dec_ready held at 1 with mem_ack always 1 -> requests to addresses 0,1,2,3, each exactly 3 cycles apart, with one en_ir per word.
REQ-038 Scenario: redirect to 16'h0040 in HOLD -> fetch_valid falls, next mem_addr=16'h0040, pc=16'h0041 after ack.
REQ-039 Scenario: redirect to 16'h0100 in REQ, with ack delayed 3 cycles -> mem_addr unchanged until ack, no en_ir, next request at 16'h0100.
REQ-040 Scenario: pc=16'hFFFF, fetch completes -> pc=16'h0000.
REQ-041 Scenario: rst asserted during REQ with mem_ack pending -> mem_req=0 at once, pc=RESET_VEC, no en_ir after release until start.
